ascon_block_feeder: RTL

- Upstream stage of the ASCON128 control FSM.
- Accepts 32-bit words from the host interface through a valid/ready handshake and packs them into 64-bit rate blocks. Applies ASCON 10* padding at the end of each segment (associated data, then plaintext).
- Presents each block with a level data_valid_o and holds it until the FSM consumes it through data_ack_i, which is driven by the FSM's xor-up enable.
- Drives the block index consumed by the FSM's block_i input.

---
 rtl/ascon_block_feeder_pkg.sv | 22 ++
 rtl/ascon_block_feeder_if.sv | 25 ++
 rtl/ascon_block_feeder_pad_word.sv | 26 ++
 rtl/ascon_block_feeder.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/ascon_block_feeder_pkg.sv
// Shared types and constants for the ASCON rate-block feeder.
// Imported by the interface, pad helper and top.
package ascon_block_feeder_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL_HI,
    S_FILL_LO,
    S_PRESENT,
    S_PAD,
    S_DONE
  } feeder_state_t;

  localparam logic [7:0]  PAD_BYTE  = 8'h80;
  localparam logic [63:0] PAD_BLOCK = 64'h80000000_00000000;

  // Out-of-range byte counts behave as a full word.
  function automatic logic [2:0] eff_nbytes(input logic [2:0] n);
    return (n >= 3'd1 && n <= 3'd3) ? n : 3'd4;
  endfunction

endpackage

// File: rtl/ascon_block_feeder_if.sv
// Host word handshake between the host and the block feeder.
// Host drives words as master, the feeder is the slave.
interface ascon_block_feeder_if;
  logic [31:0] word_i;
  logic        word_valid_i;
  logic        word_last_i;
  logic [2:0]  word_nbytes_i;
  logic        word_ready_o;

  modport master (
    output word_i,
    output word_valid_i,
    output word_last_i,
    output word_nbytes_i,
    input  word_ready_o
  );

  modport slave (
    input  word_i,
    input  word_valid_i,
    input  word_last_i,
    input  word_nbytes_i,
    output word_ready_o
  );
endinterface

// File: rtl/ascon_block_feeder_pad_word.sv
// ASCON 10* padding of one 32-bit word holding nbytes valid bytes.
// o_full flags a full word, where the pad byte spills past it.
module ascon_pad_word
  import ascon_block_feeder_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [2:0]  i_nbytes,
  output logic [31:0] o_word,
  output logic        o_full
);

  logic [2:0] w_n;

  always_comb begin
    w_n    = eff_nbytes(i_nbytes);
    o_full = (w_n == 3'd4);
    o_word = i_word;
    unique case (1'b1)
      (w_n == 3'd1): o_word = {i_word[31:24], PAD_BYTE, 16'h0};
      (w_n == 3'd2): o_word = {i_word[31:16], PAD_BYTE, 8'h0};
      (w_n == 3'd3): o_word = {i_word[31:8], PAD_BYTE};
      default:       o_word = i_word;
    endcase
  end

endmodule

// File: rtl/ascon_block_feeder.sv
// Packs host words into padded 64-bit ASCON rate blocks
// and hands them to the control FSM with a valid/ack pair.
module ascon_block_feeder
  import ascon_block_feeder_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  ascon_block_feeder_if.slave host,
  output logic [63:0]      block_o,
  output logic             data_valid_o,
  input  logic             data_ack_i,
  output logic             ad_o,
  output logic [IDX_W-1:0] block_idx_o,
  output logic             all_sent_o
);

  feeder_state_t    r_state;
  feeder_state_t    w_next;
  logic [63:0]      r_block;
  logic             r_ad;
  logic [IDX_W-1:0] r_idx;
  logic             r_pad_pending;
  logic             r_seg_end;

  logic        w_ready;
  logic        w_accept;
  logic        w_ack;
  logic [31:0] w_pad_word;
  logic        w_full;

  ascon_pad_word u_pad (
    .i_word   (host.word_i),
    .i_nbytes (host.word_nbytes_i),
    .o_word   (w_pad_word),
    .o_full   (w_full)
  );

  assign w_accept = host.word_valid_i & w_ready;
  assign w_ack    = data_ack_i & (r_state == S_PRESENT);

  always_ff @(posedge clock_i) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (start_i) begin
      w_next = S_FILL_HI;
    end else begin
      unique case (r_state)
        S_IDLE: w_next = S_IDLE;
        S_FILL_HI:
          if (w_accept)
            w_next = host.word_last_i ? S_PRESENT : S_FILL_LO;
        S_FILL_LO:
          if (w_accept) w_next = S_PRESENT;
        S_PRESENT:
          if (w_ack) begin
            if (r_pad_pending)           w_next = S_PAD;
            else if (r_seg_end && !r_ad) w_next = S_DONE;
            else                         w_next = S_FILL_HI;
          end
        S_PAD:  w_next = S_PRESENT;
        S_DONE: w_next = S_DONE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_ready      = 1'b0;
    data_valid_o = 1'b0;
    all_sent_o   = 1'b0;
    unique case (r_state)
      S_FILL_HI: w_ready      = 1'b1;
      S_FILL_LO: w_ready      = 1'b1;
      S_PRESENT: data_valid_o = 1'b1;
      S_DONE:    all_sent_o   = 1'b1;
      default: ;
    endcase
  end

  assign host.word_ready_o = w_ready;

  // Block, index and segment flags; start_i wipes a partial block.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_block       <= '0;
      r_ad          <= 1'b0;
      r_idx         <= '0;
      r_pad_pending <= 1'b0;
      r_seg_end     <= 1'b0;
    end else if (start_i) begin
      r_block       <= '0;
      r_ad          <= 1'b1;
      r_idx         <= '0;
      r_pad_pending <= 1'b0;
      r_seg_end     <= 1'b0;
    end else begin
      unique case (r_state)
        S_FILL_HI:
          if (w_accept) begin
            if (host.word_last_i) begin
              r_seg_end <= 1'b1;
              r_block <= {w_pad_word,
                          w_full ? {PAD_BYTE, 24'h0} : 32'h0};
            end else begin
              r_block[63:32] <= host.word_i;
            end
          end
        S_FILL_LO:
          if (w_accept) begin
            if (host.word_last_i) begin
              r_seg_end      <= 1'b1;
              r_pad_pending  <= w_full;
              r_block[31:0]  <= w_pad_word;
            end else begin
              r_block[31:0]  <= host.word_i;
            end
          end
        S_PRESENT:
          if (w_ack) begin
            if (r_idx != '1) r_idx <= r_idx + IDX_W'(1);
            if (!r_pad_pending && r_seg_end && r_ad) begin
              r_ad      <= 1'b0;
              r_seg_end <= 1'b0;
            end
          end
        S_PAD: begin
          r_block       <= PAD_BLOCK;
          r_pad_pending <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign block_o     = r_block;
  assign ad_o        = r_ad;
  assign block_idx_o = r_idx;

endmodule
